// File: rtl/iir_sample_source.sv
// Sample transmitter feeding the IIR filter din/vin port from a preloaded block,
// with a programmable idle gap between beats, optional looping and an end-of-run flag.
//
// state    | meaning
// IDLE     | waiting for start; memory writable
// SEND     | issue mem[addr] as a 1-cycle beat (visible on dout/vout next cycle)
// GAP      | idle cycles between beats, gap_r long
// DRAIN    | DRAIN_CYC idle cycles after the last sample of a non-looping run
// DONE     | run finished, end_sim held; memory writable, restartable
module iir_sample_source #(
  parameter int NB        = 9,
  parameter int AW        = 4,
  parameter int DRAIN_CYC = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [NB-1:0] load_data,
  input  logic [AW:0]   len,
  input  logic [3:0]    gap,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic [NB-1:0] dout,
  output logic          vout,
  output logic          busy,
  output logic          end_sim,
  output logic [15:0]   sample_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = ($clog2(DRAIN_CYC + 1) > 4) ? $clog2(DRAIN_CYC + 1) : 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [NB-1:0] mem [DEPTH];
  logic [2:0]    state;
  logic [AW-1:0] addr;
  logic [AW:0]   len_r;
  logic [AW:0]   len_m1;
  logic [3:0]    gap_r;
  logic          loop_r;
  logic [CW-1:0] cnt;
  logic          idle_like;
  logic          last;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign len_m1    = len_r - (AW+1)'(1);
  assign last      = ({1'b0, addr} == len_m1);

  // Writes land before a same-cycle start is acted on, so that run sees the new data.
  always_ff @(posedge clock) begin
    if (load_en && idle_like) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      len_r      <= '0;
      gap_r      <= '0;
      loop_r     <= 1'b0;
      cnt        <= '0;
      dout       <= '0;
      vout       <= 1'b0;
      busy       <= 1'b0;
      end_sim    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      vout <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        end_sim <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start && (len != '0)) begin
              state      <= ST_SEND;
              len_r      <= len;
              gap_r      <= gap;
              loop_r     <= loop_en;
              addr       <= '0;
              sample_cnt <= '0;
              end_sim    <= 1'b0;
              busy       <= 1'b1;
            end
          end
          ST_SEND: begin
            vout <= 1'b1;
            dout <= mem[addr];
            if (sample_cnt != 16'hFFFF) begin
              sample_cnt <= sample_cnt + 16'd1;
            end
            if (last && !loop_r) begin
              state <= ST_DRAIN;
              cnt   <= CW'(DRAIN_CYC);
            end else begin
              addr <= last ? '0 : addr + AW'(1);
              if (gap_r != '0) begin
                state <= ST_GAP;
                cnt   <= CW'(gap_r);
              end else begin
                state <= ST_SEND;
              end
            end
          end
          ST_GAP: begin
            if (cnt == CW'(1)) begin
              state <= ST_SEND;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_DRAIN: begin
            if (cnt == CW'(1)) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              end_sim <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_sample_source.sv
// Bench for iir_sample_source: a queue of expected samples is filled when a run is
// started and drained as beats appear; timing of beats and drain is checked alongside.
module tb_iir_sample_source;

  localparam int NB        = 9;
  localparam int AW        = 4;
  localparam int DRAIN_CYC = 8;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [NB-1:0] load_data;
  logic [AW:0]   len;
  logic [3:0]    gap;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic [NB-1:0] dout;
  logic          vout;
  logic          busy;
  logic          end_sim;
  logic [15:0]   sample_cnt;

  iir_sample_source #(.NB(NB), .AW(AW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clock(clock), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .len(len), .gap(gap), .loop_en(loop_en), .start(start),
    .stop(stop), .dout(dout), .vout(vout), .busy(busy), .end_sim(end_sim),
    .sample_cnt(sample_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int            checks = 0;
  int            failures = 0;
  logic [NB-1:0] model_mem [16];
  logic [NB-1:0] exp_q [$];
  int            total_beats = 0;
  int            run_base = 0;
  int            start_cyc = 0;
  int            exp_sp = 1;
  int            last_beat_cyc = 0;
  logic [NB-1:0] last_dout = '0;
  logic [NB-1:0] e;
  bit            hold_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called once per negedge: scoreboard pop and beat timing.
  task automatic observe();
    if (rst_n && vout) begin
      total_beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e));
      end
      if (total_beats - run_base == 1) check("latency", cyc, start_cyc + 2);
      else check("spacing", cyc - last_beat_cyc, exp_sp);
      last_beat_cyc = cyc;
      last_dout = dout;
    end else if (rst_n && hold_chk && busy) begin
      check("gap_hold", 32'(dout), 32'(last_dout));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    observe();
  endtask

  task automatic load_word(input int a, input logic [NB-1:0] d, input bit upd);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    if (upd) model_mem[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_run(input int l, input int g, input bit lp, input int nloop,
                           input bit ld, input logic [NB-1:0] ld_val);
    if (ld) begin
      load_en = 1'b1; load_addr = '0; load_data = ld_val; model_mem[0] = ld_val;
    end
    len = (AW+1)'(l); gap = 4'(g); loop_en = lp; start = 1'b1;
    start_cyc = cyc; run_base = total_beats; exp_sp = g + 1;
    if (lp) for (int i = 0; i < nloop; i++) exp_q.push_back(model_mem[i % l]);
    else    for (int i = 0; i < l; i++) exp_q.push_back(model_mem[i]);
    tick();
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic wait_end(input int budget, input int nexp);
    int n = 0;
    while (!end_sim && n < budget) begin
      tick();
      n++;
    end
    check("end_sim_timeout", 32'(end_sim), 1);
    check("drain_cycles", cyc - last_beat_cyc, DRAIN_CYC);
    check("beats", total_beats - run_base, nexp);
    check("sample_cnt", 32'(sample_cnt), nexp);
    check("queue_empty", exp_q.size(), 0);
    check("busy_done", 32'(busy), 0);
  endtask

  task automatic stop_after(input int nbeats);
    repeat (nbeats) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_vout", 32'(vout), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_end_sim", 32'(end_sim), 0);
    check("stop_cnt", 32'(sample_cnt), nbeats);
    check("stop_queue", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; len = '0;
    gap = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    tick(); tick();
    check("rst_dout", 32'(dout), 0);
    check("rst_vout", 32'(vout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_end_sim", 32'(end_sim), 0);
    check("rst_cnt", 32'(sample_cnt), 0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back beats, then drain to end_sim
    load_word(0, 9'h001, 1); load_word(1, 9'h1FE, 1);
    load_word(2, 9'h003, 1); load_word(3, 9'h1FC, 1);
    start_run(4, 0, 0, 0, 0, '0);
    check("busy_run", 32'(busy), 1);
    wait_end(100, 4);

    // 2: gap of 2, dout must hold between beats
    hold_chk = 1'b1;
    start_run(4, 2, 0, 0, 0, '0);
    wait_end(100, 4);
    hold_chk = 1'b0;

    // 3: looping, stopped after 7 beats
    start_run(2, 0, 1, 7, 0, '0);
    stop_after(7);
    repeat (20) tick();
    check("loop_no_end_sim", 32'(end_sim), 0);
    check("loop_extra_beats", total_beats - run_base, 7);

    // 4: len=0 is ignored; loads while busy are dropped
    start_run(0, 0, 0, 0, 0, '0);
    repeat (5) tick();
    check("len0_busy", 32'(busy), 0);
    check("len0_vout", 32'(vout), 0);
    check("len0_beats", total_beats - run_base, 0);
    start_run(4, 2, 0, 0, 0, '0);
    load_word(2, 9'h055, 0);
    wait_end(100, 4);
    start_run(4, 0, 0, 0, 0, '0);
    wait_end(100, 4);

    // 6: restart from DONE, full depth, looping across 15->0, load+start together
    check("done_end_sim", 32'(end_sim), 1);
    for (int i = 1; i < 16; i++) load_word(i, NB'(i * 7 - 50), 1);
    start_run(16, 0, 1, 18, 1, 9'h0AA);
    check("restart_end_sim", 32'(end_sim), 0);
    check("restart_busy", 32'(busy), 1);
    stop_after(18);

    // 5: async reset in the second gap cycle
    start_run(4, 2, 0, 0, 0, '0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_vout", 32'(vout), 0);
    check("arst_dout", 32'(dout), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_cnt", 32'(sample_cnt), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("arst_beats", total_beats - run_base, 1);
    check("arst_busy_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
